mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port combinational memory (address/data_in/data_out/we) between NREQ masters:
//  port 0 = core load/store/fetch port, port 1 = debug/dump master, further ports optional.
//  Round-robin grant, optional lock for multi-access sequences, MAX_HOLD anti-starvation
//  limit, registered read data. The core stalls its multicycle FSM while gnt[0]=0.
// PARAMETERS
//  NREQ      2   number of requesters (2..8)
//  AW        32  address width
//  DW        32  data width
//  MAX_HOLD  16  max consecutive locked grants to one owner while another req is pending (>=1)
// PORTS
//  clk        in   1         clock, all state on posedge
//  reset      in   1         asynchronous, active-high reset
//  req        in   NREQ      per-requester access request, held until served
//  lock       in   NREQ      keep ownership after the current access (burst/read-modify-write)
//  we         in   NREQ      per-requester write enable
//  addr       in   NREQ*AW   flattened; requester i at [i*AW +: AW]
//  wdata      in   NREQ*DW   flattened; requester i at [i*DW +: DW]
//  gnt        out  NREQ      one-hot or zero; access of owner performed in this cycle
//  rvalid     out  NREQ      one-cycle pulse, rdata valid for that requester
//  rdata      out  DW        registered read data
//  mem_addr   out  AW        to memory address
//  mem_wdata  out  DW        to memory data_in
//  mem_we     out  1         to memory we
//  mem_rdata  in   DW        from memory data_out (combinational)
// BEHAVIOUR
//  - Reset (async): state=IDLE, owner=0, rr_ptr=0, hold_cnt=0, gnt=0, rvalid=0, rdata=0;
//    mem_addr=0, mem_wdata=0, mem_we=0. An in-flight read is dropped, no rvalid after reset.
//  - States: IDLE (no owner), BUSY (owner registered). gnt[i]=(state==BUSY)&&(owner==i).
//  - Arbitration at each posedge when IDLE, or when BUSY and owner releases:
//    release = !req[owner] || !lock[owner] || (hold_cnt==MAX_HOLD-1 && any other req).
//    Winner = first set req[] scanning rr_ptr, rr_ptr+1, ... mod NREQ. Winner found -> BUSY,
//    owner=winner, rr_ptr=(winner+1) mod NREQ, hold_cnt=0. None -> IDLE.
//  - Stay BUSY without release: hold_cnt+1 (saturates at MAX_HOLD-1 when no one else waits).
//  - Latency: req rises in cycle N (IDLE, uncontested) -> gnt in N+1 -> rvalid/rdata in N+2.
//    Unlocked owners re-arbitrate every cycle; back-to-back grants with no idle cycle.
//  - Memory side, combinational from owner: mem_addr=addr[owner], mem_wdata=wdata[owner],
//    mem_we=gnt[owner]&&req[owner]&&we[owner]; all zero when IDLE. If req drops while granted:
//    no write, no rvalid.
//  - Read capture: at posedge, if gnt[o]&&req[o]&&!we[o]: rdata<=mem_rdata, rvalid[o]<=1,
//    else rvalid<=0; rdata holds last value. Writes produce no rvalid.
//  - Simultaneous req from all ports in IDLE after reset -> port 0 first, then 1, ...
//  - Anti-starvation: lock may be ignored after MAX_HOLD grants; a forced-out locked owner
//    re-competes in round-robin order (lowest priority this round).
//  - Width rule: owner, rr_ptr = clog2(NREQ) bits; hold_cnt = clog2(MAX_HOLD) bits, min 1.
// STRUCTURE
//  - Shared mem_arb_pkg (include header): state encodings ST_IDLE/ST_BUSY, clog2 function.
//  - Sub-module rr_picker: combinational; req + rr_ptr -> found, winner index.
//  - Top: state/owner/rr_ptr/hold_cnt regs, output muxes, rdata/rvalid capture reg.
// TESTING
//  1 reset=1 mid-read (gnt[1] high) -> all outputs 0 immediately; no rvalid after release.
//  2 req=2'b01 at addr 0x10, mem word 0xDEADBEEF -> gnt[0] next cycle; rvalid[0] plus
//    rdata=0xDEADBEEF the following cycle.
//  3 req=2'b11 held, no lock, from reset -> gnt alternates 01,10,01,10; no idle cycles.
//  4 port1 write addr 0x20 data 0x12345678 -> mem_we=1 one cycle; port0 reads 0x20 -> 0x12345678.
//  5 port0 lock=1, req=1; port1 req=1 (MAX_HOLD=16) -> port0 keeps gnt 16 cycles, then gnt[1].
//  6 port0 granted, req[0] drops same cycle -> mem_we=0, no rvalid[0]; port1 granted next edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and a
// constant-evaluable clog2 used to size index and counter registers.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: finds the first active request at or above the
// rotating pointer, wrapping around to the lowest index when none is found above.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   winner
);

    logic [NREQ-1:0] upper_req;

    // Requests at or above the pointer get first chance in this round
    always_comb begin
        upper_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_req[i] = req[i] && (IW'(i) >= rr_ptr);
        end
    end

    // Lowest active request overall, overridden by the lowest one at/above the pointer
    always_comb begin
        found  = |req;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port combinational memory between NREQ masters.
// Round-robin grant, optional lock for multi-access sequences with a MAX_HOLD
// starvation limit, and a registered read-data return path.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_we,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int IW = clog2(NREQ);
    localparam int HW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;

    logic          busy;
    logic          own_req;
    logic          own_lock;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          others_waiting;
    logic          release_own;
    logic          rearbitrate;
    logic          pick_found;
    logic [IW-1:0] pick_winner;
    logic [IW-1:0] next_ptr;

    assign busy = (state == ST_BUSY);

    // Select the current owner's request, lock, and access fields
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                own_req   = req[i];
                own_lock  = lock[i];
                own_we    = we[i];
                own_addr  = addr[i*AW +: AW];
                own_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // Grant is a one-hot decode of the registered owner while busy
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = busy && (owner == IW'(i));
        end
    end

    // Owner gives up the memory when done, unlocked, or held too long against a waiting master
    always_comb begin
        others_waiting = |(req & ~gnt);
        release_own    = !own_req || !own_lock || ((hold_cnt == HOLD_LAST) && others_waiting);
        rearbitrate    = !busy || release_own;
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .winner (pick_winner)
    );

    assign next_ptr = (pick_winner == IW'(NREQ - 1)) ? '0 : pick_winner + IW'(1);

    // Memory side follows the owner directly; nothing is driven while idle
    always_comb begin
        mem_addr  = busy ? own_addr : '0;
        mem_wdata = busy ? own_wdata : '0;
        mem_we    = busy && own_req && own_we;
    end

    // Ownership FSM: re-arbitrate on release, otherwise count consecutive locked grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else if (rearbitrate) begin
            hold_cnt <= '0;
            if (pick_found) begin
                state  <= ST_BUSY;
                owner  <= pick_winner;
                rr_ptr <= next_ptr;
            end else begin
                state <= ST_IDLE;
            end
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // Capture read data for the owner's read and pulse its rvalid for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= '0;
        end else begin
            rvalid <= '0;
            if (busy && own_req && !own_we) begin
                rdata  <= mem_rdata;
                rvalid <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small word memory model.
module tb_mem_arbiter;

    localparam int NREQ     = 2;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 16;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ-1:0]     we;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rvalid;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_we;
    logic [DW-1:0]       mem_rdata;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory: preloaded while reset is high, written on posedge when mem_we is set
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= '0;
            end
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'h0BADF00D;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w);
        req  = r;
        lock = l;
        we   = w;
    endtask

    task automatic setPort(input int idx, input logic [31:0] a, input logic [31:0] d);
        addr[idx*AW +: AW]  = a;
        wdata[idx*DW +: DW] = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_gnt", 64'(gnt), 64'h0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'h0);
        checkOutput("rst_rdata", 64'(rdata), 64'h0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'h0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        reset = 1'b0;

        $display("[TB] single read latency");
        setPort(0, 32'h10, 32'h0);
        applyStimulus(2'b01, 2'b00, 2'b00);
        #1;
        checkOutput("rd_idle_gnt", 64'(gnt), 64'h0);
        nextCycle();
        checkOutput("rd_gnt", 64'(gnt), 64'h1);
        checkOutput("rd_mem_addr", 64'(mem_addr), 64'h10);
        checkOutput("rd_no_rvalid_yet", 64'(rvalid), 64'h0);
        nextCycle();
        checkOutput("rd_rvalid", 64'(rvalid), 64'h1);
        checkOutput("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        applyStimulus(2'b00, 2'b00, 2'b00);
        nextCycle();
        checkOutput("rd_done_gnt", 64'(gnt), 64'h0);
        checkOutput("rd_done_rvalid", 64'(rvalid), 64'h0);
        checkOutput("rd_rdata_hold", 64'(rdata), 64'hDEADBEEF);

        $display("[TB] reset during read");
        setPort(1, 32'h20, 32'h0);
        applyStimulus(2'b10, 2'b00, 2'b00);
        nextCycle();
        checkOutput("mid_gnt", 64'(gnt), 64'h2);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_gnt", 64'(gnt), 64'h0);
        checkOutput("mid_rst_rvalid", 64'(rvalid), 64'h0);
        checkOutput("mid_rst_rdata", 64'(rdata), 64'h0);
        checkOutput("mid_rst_mem_addr", 64'(mem_addr), 64'h0);
        checkOutput("mid_rst_mem_we", 64'(mem_we), 64'h0);
        applyStimulus(2'b00, 2'b00, 2'b00);
        nextCycle();
        reset = 1'b0;
        nextCycle();
        checkOutput("post_rst_rvalid", 64'(rvalid), 64'h0);
        checkOutput("post_rst_gnt", 64'(gnt), 64'h0);

        $display("[TB] unlocked alternation");
        setPort(0, 32'h10, 32'h0);
        setPort(1, 32'h20, 32'h0);
        applyStimulus(2'b11, 2'b00, 2'b00);
        nextCycle();
        checkOutput("alt_gnt_a", 64'(gnt), 64'h1);
        nextCycle();
        checkOutput("alt_gnt_b", 64'(gnt), 64'h2);
        checkOutput("alt_rvalid_b", 64'(rvalid), 64'h1);
        checkOutput("alt_rdata_b", 64'(rdata), 64'hDEADBEEF);
        nextCycle();
        checkOutput("alt_gnt_c", 64'(gnt), 64'h1);
        checkOutput("alt_rvalid_c", 64'(rvalid), 64'h2);
        checkOutput("alt_rdata_c", 64'(rdata), 64'h0BADF00D);
        nextCycle();
        checkOutput("alt_gnt_d", 64'(gnt), 64'h2);
        applyStimulus(2'b00, 2'b00, 2'b00);
        nextCycle();
        checkOutput("alt_idle_gnt", 64'(gnt), 64'h0);

        $display("[TB] write then read back");
        setPort(1, 32'h20, 32'h12345678);
        applyStimulus(2'b10, 2'b00, 2'b10);
        #1;
        checkOutput("wr_idle_we", 64'(mem_we), 64'h0);
        nextCycle();
        checkOutput("wr_gnt", 64'(gnt), 64'h2);
        checkOutput("wr_mem_we", 64'(mem_we), 64'h1);
        checkOutput("wr_mem_addr", 64'(mem_addr), 64'h20);
        checkOutput("wr_mem_wdata", 64'(mem_wdata), 64'h12345678);
        nextCycle();
        checkOutput("wr_no_rvalid", 64'(rvalid), 64'h0);
        setPort(0, 32'h20, 32'h0);
        applyStimulus(2'b01, 2'b00, 2'b00);
        #1;
        checkOutput("wr_released_we", 64'(mem_we), 64'h0);
        nextCycle();
        checkOutput("rb_gnt", 64'(gnt), 64'h1);
        nextCycle();
        checkOutput("rb_rvalid", 64'(rvalid), 64'h1);
        checkOutput("rb_rdata", 64'(rdata), 64'h12345678);
        applyStimulus(2'b00, 2'b00, 2'b00);
        nextCycle();

        $display("[TB] lock with hold limit");
        pulseReset();
        setPort(0, 32'h10, 32'h0);
        setPort(1, 32'h20, 32'h0);
        applyStimulus(2'b11, 2'b01, 2'b00);
        for (int k = 0; k < MAX_HOLD; k++) begin
            nextCycle();
            checkOutput($sformatf("lock_hold_%0d", k), 64'(gnt), 64'h1);
        end
        nextCycle();
        checkOutput("lock_forced_out", 64'(gnt), 64'h2);
        nextCycle();
        checkOutput("lock_owner_back", 64'(gnt), 64'h1);
        applyStimulus(2'b00, 2'b00, 2'b00);
        nextCycle();
        checkOutput("lock_idle", 64'(gnt), 64'h0);

        $display("[TB] request dropped while granted");
        setPort(0, 32'h30, 32'hAAAA5555);
        applyStimulus(2'b01, 2'b00, 2'b01);
        nextCycle();
        checkOutput("drop_gnt", 64'(gnt), 64'h1);
        checkOutput("drop_we_before", 64'(mem_we), 64'h1);
        setPort(1, 32'h10, 32'h0);
        applyStimulus(2'b10, 2'b00, 2'b00);
        #1;
        checkOutput("drop_we_after", 64'(mem_we), 64'h0);
        nextCycle();
        checkOutput("drop_next_gnt", 64'(gnt), 64'h2);
        checkOutput("drop_no_rvalid", 64'(rvalid), 64'h0);
        nextCycle();
        checkOutput("drop_p1_rvalid", 64'(rvalid), 64'h2);
        checkOutput("drop_p1_rdata", 64'(rdata), 64'hDEADBEEF);
        setPort(0, 32'h30, 32'h0);
        applyStimulus(2'b01, 2'b00, 2'b00);
        nextCycle();
        checkOutput("drop_rb_gnt", 64'(gnt), 64'h1);
        nextCycle();
        checkOutput("drop_rb_rvalid", 64'(rvalid), 64'h1);
        checkOutput("drop_rb_unwritten", 64'(rdata), 64'h0);
        applyStimulus(2'b00, 2'b00, 2'b00);
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
